// File: rtl/operand_fetch_pkg.sv
// Shared widths, defaults and the operand bundle type for the operand-fetch stage.
// R15 has no storage: it always reads as the instruction PC plus a fixed offset.
package operand_fetch_pkg;

    localparam int WORD          = 32;
    localparam int REG_ADDR      = 4;
    localparam int DEF_NUM_REGS  = 16;
    localparam int DEF_PEND_W    = 2;
    localparam int DEF_PC_OFFSET = 8;
    localparam int PC_IDX        = 15;

    typedef logic [WORD-1:0]     word_t;
    typedef logic [REG_ADDR-1:0] raddr_t;

    typedef struct packed {
        word_t  rn_data;
        word_t  rm_data;
        raddr_t rd_addr;
        logic   rd_write;
        word_t  pc;
    } op_bundle_t;

    function automatic logic is_pc(input raddr_t a);
        return a == raddr_t'(PC_IDX);
    endfunction

endpackage

// File: rtl/operand_fetch_reg_file.sv
// Architectural register file: one write port, two combinational read ports with
// same-cycle write-back bypass and the R15 = PC + offset substitution.
module reg_file
    import operand_fetch_pkg::*;
#(
    parameter int NUM_REGS  = DEF_NUM_REGS,
    parameter int PC_OFFSET = DEF_PC_OFFSET
) (
    input  logic   clk_i,
    input  logic   rst_i,
    input  logic   wb_write_i,
    input  raddr_t wb_addr_i,
    input  word_t  wb_data_i,
    input  word_t  pc_i,
    input  raddr_t ra_addr_i,
    input  raddr_t rb_addr_i,
    output word_t  ra_data_o,
    output word_t  rb_data_o
);

    word_t regs_q [NUM_REGS-1];
    word_t pc_read;
    logic  wb_valid;

    assign pc_read  = pc_i + word_t'(PC_OFFSET);
    assign wb_valid = wb_write_i && !is_pc(wb_addr_i);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < NUM_REGS - 1; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wb_valid) begin
            regs_q[wb_addr_i] <= wb_data_i;
        end
    end

    always_comb begin
        ra_data_o = '0;
        if (is_pc(ra_addr_i)) begin
            ra_data_o = pc_read;
        end else if (wb_valid && wb_addr_i == ra_addr_i) begin
            ra_data_o = wb_data_i;
        end else begin
            ra_data_o = regs_q[ra_addr_i];
        end
    end

    always_comb begin
        rb_data_o = '0;
        if (is_pc(rb_addr_i)) begin
            rb_data_o = pc_read;
        end else if (wb_valid && wb_addr_i == rb_addr_i) begin
            rb_data_o = wb_data_i;
        end else begin
            rb_data_o = regs_q[rb_addr_i];
        end
    end

endmodule

// File: rtl/operand_fetch.sv
// Operand fetch stage: register read, per-register pending-write scoreboard with RAW
// stall, and a valid/ready output register feeding execute.
module operand_fetch
    import operand_fetch_pkg::*;
#(
    parameter int NUM_REGS  = DEF_NUM_REGS,
    parameter int PEND_W    = DEF_PEND_W,
    parameter int PC_OFFSET = DEF_PC_OFFSET
) (
    input  logic   id_clk,
    input  logic   reset,
    input  logic   in_valid,
    output logic   in_ready,
    input  raddr_t rn_addr,
    input  raddr_t rm_addr,
    input  raddr_t rd_addr,
    input  logic   rd_write,
    input  word_t  pc_in,
    input  logic   wb_write,
    input  raddr_t wb_addr,
    input  word_t  wb_data,
    output logic   out_valid,
    input  logic   out_ready,
    output word_t  rn_data,
    output word_t  rm_data,
    output raddr_t rd_addr_out,
    output logic   rd_write_out,
    output word_t  pc_out
);

    localparam logic [PEND_W-1:0] PEND_MAX = '1;
    localparam logic [PEND_W-1:0] PEND_ONE = {{(PEND_W-1){1'b0}}, 1'b1};

    logic [PEND_W-1:0] pend_q [NUM_REGS];
    logic [PEND_W-1:0] pend_d [NUM_REGS];
    op_bundle_t        op_q, op_d;
    logic              out_valid_q;

    word_t rn_rd, rm_rd;
    logic  busy_n, busy_m, dest_full, stall, capture;

    reg_file #(
        .NUM_REGS  (NUM_REGS),
        .PC_OFFSET (PC_OFFSET)
    ) u_reg_file (
        .clk_i      (id_clk),
        .rst_i      (reset),
        .wb_write_i (wb_write),
        .wb_addr_i  (wb_addr),
        .wb_data_i  (wb_data),
        .pc_i       (pc_in),
        .ra_addr_i  (rn_addr),
        .rb_addr_i  (rm_addr),
        .ra_data_o  (rn_rd),
        .rb_data_o  (rm_rd)
    );

    // A source whose last outstanding write is retiring this cycle is served by the bypass.
    always_comb begin
        busy_n = !is_pc(rn_addr) && (pend_q[rn_addr] != '0)
                 && !((pend_q[rn_addr] == PEND_ONE) && wb_write && (wb_addr == rn_addr));
        busy_m = !is_pc(rm_addr) && (pend_q[rm_addr] != '0)
                 && !((pend_q[rm_addr] == PEND_ONE) && wb_write && (wb_addr == rm_addr));
        dest_full = rd_write && !is_pc(rd_addr) && (pend_q[rd_addr] == PEND_MAX)
                    && !(wb_write && (wb_addr == rd_addr));
        stall    = in_valid && (busy_n || busy_m || dest_full);
        in_ready = (!out_valid_q || out_ready) && !stall;
        capture  = in_valid && in_ready;
    end

    always_comb begin
        op_d.rn_data  = rn_rd;
        op_d.rm_data  = rm_rd;
        op_d.rd_addr  = rd_addr;
        op_d.rd_write = rd_write;
        op_d.pc       = pc_in;
    end

    always_comb begin
        logic inc, dec;
        inc = 1'b0;
        dec = 1'b0;
        for (int r = 0; r < NUM_REGS; r++) begin
            pend_d[r] = pend_q[r];
            inc = capture && rd_write && (rd_addr == raddr_t'(r)) && (r != PC_IDX);
            dec = wb_write && (wb_addr == raddr_t'(r)) && (pend_q[r] != '0) && (r != PC_IDX);
            if (inc && !dec) begin
                pend_d[r] = pend_q[r] + PEND_ONE;
            end else if (dec && !inc) begin
                pend_d[r] = pend_q[r] - PEND_ONE;
            end
        end
    end

    always_ff @(posedge id_clk or posedge reset) begin
        if (reset) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                pend_q[r] <= '0;
            end
            op_q        <= '0;
            out_valid_q <= 1'b0;
        end else begin
            for (int r = 0; r < NUM_REGS; r++) begin
                pend_q[r] <= pend_d[r];
            end
            if (capture) begin
                op_q        <= op_d;
                out_valid_q <= 1'b1;
            end else if (out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign out_valid    = out_valid_q;
    assign rn_data      = op_q.rn_data;
    assign rm_data      = op_q.rm_data;
    assign rd_addr_out  = op_q.rd_addr;
    assign rd_write_out = op_q.rd_write;
    assign pc_out       = op_q.pc;

endmodule

// File: tb/tb_operand_fetch.sv
// Self-checking bench for operand_fetch: a behavioural model predicts in_ready and the
// captured operands, which queue up and are compared while the DUT holds them.
module tb_operand_fetch;

    logic        id_clk = 1'b0;
    logic        reset;
    logic        in_valid, in_ready;
    logic [3:0]  rn_addr, rm_addr, rd_addr;
    logic        rd_write;
    logic [31:0] pc_in;
    logic        wb_write;
    logic [3:0]  wb_addr;
    logic [31:0] wb_data;
    logic        out_valid, out_ready;
    logic [31:0] rn_data, rm_data, pc_out;
    logic [3:0]  rd_addr_out;
    logic        rd_write_out;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [31:0] rn;
        logic [31:0] rm;
        logic [3:0]  rd;
        logic        rdw;
        logic [31:0] pc;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] mregs [16];
    int          mpend [16];
    bit          mvalid;

    always #5 id_clk = ~id_clk;

    operand_fetch dut (
        .id_clk       (id_clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .rn_addr      (rn_addr),
        .rm_addr      (rm_addr),
        .rd_addr      (rd_addr),
        .rd_write     (rd_write),
        .pc_in        (pc_in),
        .wb_write     (wb_write),
        .wb_addr      (wb_addr),
        .wb_data      (wb_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .rn_data      (rn_data),
        .rm_data      (rm_data),
        .rd_addr_out  (rd_addr_out),
        .rd_write_out (rd_write_out),
        .pc_out       (pc_out)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mread(input logic [3:0] a);
        if (a == 4'd15) return pc_in + 32'd8;
        if (wb_write && wb_addr == a) return wb_data;
        return mregs[a];
    endfunction

    function automatic bit src_busy(input logic [3:0] s);
        if (s == 4'd15) return 1'b0;
        if (mpend[s] == 0) return 1'b0;
        return !(mpend[s] == 1 && wb_write && wb_addr == s);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) begin
            mregs[i] = '0;
            mpend[i] = 0;
        end
        mvalid = 1'b0;
        exp_q.delete();
    endtask

    task automatic drive(input bit v, input logic [3:0] rn, input logic [3:0] rm,
                         input logic [3:0] rd, input bit rdw, input logic [31:0] pc);
        in_valid = v;
        rn_addr  = rn;
        rm_addr  = rm;
        rd_addr  = rd;
        rd_write = rdw;
        pc_in    = pc;
    endtask

    task automatic wb(input bit w, input logic [3:0] a, input logic [31:0] d);
        wb_write = w;
        wb_addr  = a;
        wb_data  = d;
    endtask

    // One clock: check at the falling edge, advance the model, return just after the rising edge.
    task automatic tick();
        bit   full, stall, rdy, cap, inc, dec;
        exp_t e;
        @(negedge id_clk);
        full  = rd_write && rd_addr != 4'd15 && mpend[rd_addr] == 3
                && !(wb_write && wb_addr == rd_addr);
        stall = in_valid && (src_busy(rn_addr) || src_busy(rm_addr) || full);
        rdy   = (!mvalid || out_ready) && !stall;
        cap   = in_valid && rdy;
        check_eq("in_ready", 32'(in_ready), 32'(rdy));
        check_eq("out_valid", 32'(out_valid), 32'(mvalid));
        if (mvalid) begin
            check_eq("exp_queue_nonempty", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q[0];
                check_eq("rn_data", rn_data, e.rn);
                check_eq("rm_data", rm_data, e.rm);
                check_eq("rd_addr_out", 32'(rd_addr_out), 32'(e.rd));
                check_eq("rd_write_out", 32'(rd_write_out), 32'(e.rdw));
                check_eq("pc_out", pc_out, e.pc);
            end
        end
        if (mvalid && out_ready && exp_q.size() != 0) void'(exp_q.pop_front());
        if (cap) begin
            e.rn  = mread(rn_addr);
            e.rm  = mread(rm_addr);
            e.rd  = rd_addr;
            e.rdw = rd_write;
            e.pc  = pc_in;
            exp_q.push_back(e);
        end
        mvalid = cap ? 1'b1 : (out_ready ? 1'b0 : mvalid);
        for (int r = 0; r < 15; r++) begin
            inc = cap && rd_write && rd_addr == 4'(r);
            dec = wb_write && wb_addr == 4'(r) && mpend[r] != 0;
            if (inc && !dec) mpend[r]++;
            else if (dec && !inc) mpend[r]--;
        end
        if (wb_write && wb_addr != 4'd15) mregs[wb_addr] = wb_data;
        @(posedge id_clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        out_ready = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        wb(0, 0, 0);
        model_reset();
        #12;
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_rn_data", rn_data, 32'd0);
        check_eq("rst_rm_data", rm_data, 32'd0);
        check_eq("rst_pc_out", pc_out, 32'd0);
        check_eq("rst_rd_addr_out", 32'(rd_addr_out), 32'd0);
        check_eq("rst_rd_write_out", 32'(rd_write_out), 32'd0);
        @(posedge id_clk);
        #1 reset = 1'b0;
        out_ready = 1'b1;

        // write-back then read it back
        wb(1, 3, 32'h1234); tick();
        wb(0, 0, 0);
        drive(1, 3, 0, 1, 0, 32'h40); tick();
        drive(0, 0, 0, 0, 0, 0); tick();

        // R15 reads PC+8, write-back to R15 is ignored
        drive(1, 15, 3, 0, 0, 32'h100); tick();
        wb(1, 15, 32'hFFFF);
        drive(1, 15, 15, 0, 0, 32'h200); tick();
        wb(0, 0, 0);
        drive(1, 15, 15, 0, 0, 32'h300); tick();
        drive(0, 0, 0, 0, 0, 0); tick();

        // RAW stall released by a same-cycle write-back
        drive(1, 0, 0, 5, 1, 32'h10); tick();
        drive(1, 0, 5, 6, 0, 32'h14);
        repeat (3) tick();
        wb(1, 5, 32'hAA); tick();
        wb(0, 0, 0);
        drive(0, 0, 0, 0, 0, 0); tick();

        // back-pressure then back-to-back capture
        out_ready = 1'b0;
        drive(1, 3, 15, 7, 0, 32'h500); tick();
        drive(1, 5, 3, 8, 0, 32'h504);
        repeat (3) tick();
        out_ready = 1'b1; tick();
        drive(1, 15, 5, 9, 0, 32'h508); tick();
        drive(0, 0, 0, 0, 0, 0); tick();

        // pending-count saturation on r2
        drive(1, 0, 0, 2, 1, 32'h600);
        repeat (3) tick();
        repeat (2) tick();
        wb(1, 2, 32'h22); tick();
        wb(0, 0, 0);
        drive(1, 0, 0, 2, 1, 32'h604);
        repeat (2) tick();
        drive(0, 0, 0, 0, 0, 0);
        wb(1, 2, 32'h23); tick();
        wb(1, 2, 32'h24); tick();
        wb(1, 2, 32'h25); tick();
        wb(0, 0, 0);
        drive(1, 2, 0, 0, 0, 32'h608); tick();
        drive(0, 0, 0, 0, 0, 0); tick();

        // asynchronous reset with a held instruction and pend[4]=2
        drive(1, 0, 0, 4, 1, 32'h700);
        repeat (2) tick();
        drive(0, 0, 0, 0, 0, 0);
        out_ready = 1'b0; tick();
        #2 reset = 1'b1;
        #1;
        check_eq("async_rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("async_rst_rn_data", rn_data, 32'd0);
        check_eq("async_rst_rd_write_out", 32'(rd_write_out), 32'd0);
        model_reset();
        @(posedge id_clk);
        #1 reset = 1'b0;
        out_ready = 1'b1;
        drive(1, 4, 4, 0, 0, 32'h800); tick();
        drive(0, 0, 0, 0, 0, 0); tick();
        tick();

        check_eq("leftover_expected", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
